// File: rtl/video_scale_pkg.sv
// rtl/video_scale_pkg.sv - shared types and constants for the scaler configuration controller
package video_scale_pkg;

    localparam logic [31:0] FIX_ONE = 32'h0001_0000;

    typedef logic [15:0] res_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIV_W,
        ST_DIV_H,
        ST_PEND,
        ST_ERR
    } state_e;

    // A 1:1 axis is exactly unity; any real reduction rounds the step up by one LSB.
    function automatic logic [31:0] axis_factor(input res_t vin, input res_t vout,
                                                input logic [31:0] quo);
        return (vin == vout) ? FIX_ONE : quo + 32'd1;
    endfunction

endpackage

// File: rtl/video_scale_ctrl_if.sv
// rtl/video_scale_ctrl_if.sv - resolution request handshake bundle
interface video_scale_ctrl_if;
    import video_scale_pkg::*;

    logic cfg_valid;
    logic cfg_ready;
    res_t cfg_vin_xres;
    res_t cfg_vin_yres;
    res_t cfg_vout_xres;
    res_t cfg_vout_yres;

    modport master (
        output cfg_valid, cfg_vin_xres, cfg_vin_yres, cfg_vout_xres, cfg_vout_yres,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_vin_xres, cfg_vin_yres, cfg_vout_xres, cfg_vout_yres,
        output cfg_ready
    );

endinterface

// File: rtl/video_scale_ctrl_div.sv
// rtl/video_scale_ctrl_div.sv - 32/16 restoring serial divider, one quotient bit per cycle
module scale_div_serial (
    input  logic        vin_clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    output logic [31:0] quotient,
    output logic        done
);

    logic [31:0] dvd_q, dvd_d;
    logic [31:0] quo_q, quo_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] dsr_q, dsr_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [16:0] trial;
    logic [15:0] dsr_sel;
    logic [15:0] diff;
    logic        ge;
    logic [15:0] rem_next;

    // The start cycle already resolves quotient bit 31 so a back-to-back restart never collides with a finishing run.
    always_comb begin
        dsr_sel  = start ? divisor : dsr_q;
        trial    = start ? {16'h0, dividend[31]} : {rem_q, dvd_q[31]};
        ge       = (trial >= {1'b0, dsr_sel});
        diff     = trial[15:0] - dsr_sel;
        rem_next = ge ? diff : trial[15:0];

        dvd_d  = dvd_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        dsr_d  = dsr_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;

        if (start) begin
            dvd_d  = {dividend[30:0], 1'b0};
            quo_d  = {31'h0, ge};
            rem_d  = rem_next;
            dsr_d  = divisor;
            cnt_d  = 5'd31;
            busy_d = 1'b1;
        end else if (busy_q) begin
            dvd_d = {dvd_q[30:0], 1'b0};
            quo_d = {quo_q[30:0], ge};
            rem_d = rem_next;
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Divider state registers.
    always_ff @(posedge vin_clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            dvd_q  <= dvd_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dsr_q  <= dsr_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign quotient = quo_q;
    assign done     = done_q;

endmodule

// File: rtl/video_scale_ctrl.sv
// rtl/video_scale_ctrl.sv - computes scaler step factors and commits them on frame sync
module video_scale_ctrl
    import video_scale_pkg::*;
#(
    parameter bit COMMIT_IMMEDIATE = 1'b0
) (
    input  logic                vin_clk,
    input  logic                rst_n,
    input  logic                frame_vs,
    video_scale_ctrl_if.slave   cfg,
    output logic [31:0]         scaler_width,
    output logic [31:0]         scaler_height,
    output logic                scale_en,
    output logic                cfg_busy,
    output logic                cfg_done,
    output logic                cfg_err
);

    state_e      state_q, state_d;
    res_t        vin_x_q, vin_x_d, vin_y_q, vin_y_d;
    res_t        vout_x_q, vout_x_d, vout_y_q, vout_y_d;
    logic [31:0] shadow_w_q, shadow_w_d, shadow_h_q, shadow_h_d;
    logic [31:0] width_q, width_d, height_q, height_d;
    logic        scale_en_q, scale_en_d;
    logic        cfg_done_q, cfg_done_d;
    logic        cfg_err_q, cfg_err_d;
    logic        frame_vs_q;

    logic        accept, req_bad, vs_rise;
    logic        div_start, div_done;
    logic [31:0] div_dividend, div_quotient;
    logic [15:0] div_divisor;

    assign accept  = cfg.cfg_valid && (state_q == ST_IDLE);
    assign req_bad = (cfg.cfg_vout_xres == 16'h0) || (cfg.cfg_vout_yres == 16'h0) ||
                     (cfg.cfg_vout_xres > cfg.cfg_vin_xres) ||
                     (cfg.cfg_vout_yres > cfg.cfg_vin_yres);
    assign vs_rise = frame_vs & ~frame_vs_q;

    // Horizontal division starts straight from the request; vertical starts as horizontal finishes.
    always_comb begin
        div_start = (accept && !req_bad) || ((state_q == ST_DIV_W) && div_done);
        if (state_q == ST_IDLE) begin
            div_dividend = {cfg.cfg_vin_xres, 16'h0};
            div_divisor  = cfg.cfg_vout_xres;
        end else begin
            div_dividend = {vin_y_q, 16'h0};
            div_divisor  = vout_y_q;
        end
    end

    scale_div_serial u_div (
        .vin_clk  (vin_clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .quotient (div_quotient),
        .done     (div_done)
    );

    // Request sequencing: validate, divide both axes, then hold in shadow until the commit point.
    always_comb begin
        state_d    = state_q;
        vin_x_d    = vin_x_q;
        vin_y_d    = vin_y_q;
        vout_x_d   = vout_x_q;
        vout_y_d   = vout_y_q;
        shadow_w_d = shadow_w_q;
        shadow_h_d = shadow_h_q;
        width_d    = width_q;
        height_d   = height_q;
        scale_en_d = scale_en_q;
        cfg_err_d  = cfg_err_q;
        cfg_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    vin_x_d  = cfg.cfg_vin_xres;
                    vin_y_d  = cfg.cfg_vin_yres;
                    vout_x_d = cfg.cfg_vout_xres;
                    vout_y_d = cfg.cfg_vout_yres;
                    if (req_bad) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d   = ST_DIV_W;
                        cfg_err_d = 1'b0;
                    end
                end
            end
            ST_DIV_W: begin
                if (div_done) begin
                    shadow_w_d = axis_factor(vin_x_q, vout_x_q, div_quotient);
                    state_d    = ST_DIV_H;
                end
            end
            ST_DIV_H: begin
                if (div_done) begin
                    shadow_h_d = axis_factor(vin_y_q, vout_y_q, div_quotient);
                    state_d    = ST_PEND;
                end
            end
            ST_PEND: begin
                if (COMMIT_IMMEDIATE || vs_rise) begin
                    width_d    = shadow_w_q;
                    height_d   = shadow_h_q;
                    scale_en_d = 1'b1;
                    cfg_done_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            ST_ERR: begin
                cfg_err_d = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Controller registers; reset drops any active factors.
    always_ff @(posedge vin_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            vin_x_q    <= '0;
            vin_y_q    <= '0;
            vout_x_q   <= '0;
            vout_y_q   <= '0;
            shadow_w_q <= '0;
            shadow_h_q <= '0;
            width_q    <= '0;
            height_q   <= '0;
            scale_en_q <= 1'b0;
            cfg_done_q <= 1'b0;
            cfg_err_q  <= 1'b0;
            frame_vs_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            vin_x_q    <= vin_x_d;
            vin_y_q    <= vin_y_d;
            vout_x_q   <= vout_x_d;
            vout_y_q   <= vout_y_d;
            shadow_w_q <= shadow_w_d;
            shadow_h_q <= shadow_h_d;
            width_q    <= width_d;
            height_q   <= height_d;
            scale_en_q <= scale_en_d;
            cfg_done_q <= cfg_done_d;
            cfg_err_q  <= cfg_err_d;
            frame_vs_q <= frame_vs;
        end
    end

    assign cfg.cfg_ready  = (state_q == ST_IDLE);
    assign cfg_busy       = (state_q == ST_DIV_W) || (state_q == ST_DIV_H) || (state_q == ST_PEND);
    assign scaler_width   = width_q;
    assign scaler_height  = height_q;
    assign scale_en       = scale_en_q;
    assign cfg_done       = cfg_done_q;
    assign cfg_err        = cfg_err_q;

endmodule

// File: tb/tb_video_scale_ctrl.sv
// tb/tb_video_scale_ctrl.sv - scoreboard bench for video_scale_ctrl
module tb_video_scale_ctrl;
    import video_scale_pkg::*;

    typedef struct {
        logic [31:0] w;
        logic [31:0] h;
    } exp_t;

    logic        vin_clk = 1'b0;
    logic        rst_n;
    logic        frame_vs;
    logic        cfg_valid;
    logic        sel;
    logic [15:0] vin_x, vin_y, vout_x, vout_y;

    logic [31:0] w0, h0, w1, h1;
    logic        en0, busy0, done0, err0, en1, busy1, done1, err1;

    logic [31:0] cur_w, cur_h;
    logic        cur_en, cur_busy, cur_done, cur_err, cur_ready;

    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        exp_q[$];
    logic [31:0] last_w = '0;
    logic [31:0] last_h = '0;

    always #5 vin_clk = ~vin_clk;

    video_scale_ctrl_if if0 ();
    video_scale_ctrl_if if1 ();

    assign if0.cfg_valid     = cfg_valid & ~sel;
    assign if0.cfg_vin_xres  = vin_x;
    assign if0.cfg_vin_yres  = vin_y;
    assign if0.cfg_vout_xres = vout_x;
    assign if0.cfg_vout_yres = vout_y;
    assign if1.cfg_valid     = cfg_valid & sel;
    assign if1.cfg_vin_xres  = vin_x;
    assign if1.cfg_vin_yres  = vin_y;
    assign if1.cfg_vout_xres = vout_x;
    assign if1.cfg_vout_yres = vout_y;

    video_scale_ctrl #(.COMMIT_IMMEDIATE(1'b0)) u_dut0 (
        .vin_clk(vin_clk), .rst_n(rst_n), .frame_vs(frame_vs), .cfg(if0),
        .scaler_width(w0), .scaler_height(h0), .scale_en(en0),
        .cfg_busy(busy0), .cfg_done(done0), .cfg_err(err0)
    );

    video_scale_ctrl #(.COMMIT_IMMEDIATE(1'b1)) u_dut1 (
        .vin_clk(vin_clk), .rst_n(rst_n), .frame_vs(frame_vs), .cfg(if1),
        .scaler_width(w1), .scaler_height(h1), .scale_en(en1),
        .cfg_busy(busy1), .cfg_done(done1), .cfg_err(err1)
    );

    assign cur_w     = sel ? w1 : w0;
    assign cur_h     = sel ? h1 : h0;
    assign cur_en    = sel ? en1 : en0;
    assign cur_busy  = sel ? busy1 : busy0;
    assign cur_done  = sel ? done1 : done0;
    assign cur_err   = sel ? err1 : err0;
    assign cur_ready = sel ? if1.cfg_ready : if0.cfg_ready;

    function automatic logic [31:0] model_factor(input logic [15:0] vi, input logic [15:0] vo);
        logic [31:0] num;
        num = {vi, 16'h0};
        if (vi == vo) return 32'h0001_0000;
        return (num / {16'h0, vo}) + 32'd1;
    endfunction

    task automatic test_reset;
        rst_n = 1'b0; frame_vs = 1'b0; cfg_valid = 1'b0; sel = 1'b0;
        vin_x = '0; vin_y = '0; vout_x = '0; vout_y = '0;
        repeat (3) @(negedge vin_clk);
        n_tests++;
        if ({w0, h0, en0, busy0, done0, err0, w1, h1, en1, busy1, done1, err1} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: w=%h h=%h en=%b busy=%b done=%b err=%b, required all zero",
                     w0, h0, en0, busy0, done0, err0);
        end
        n_tests++;
        if (if0.cfg_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b required 1", if0.cfg_ready);
        end
        rst_n = 1'b1;
        @(negedge vin_clk);
    endtask

    // Drive one valid request; expect cfg_done at cycle T+done_at.
    task automatic run_req(input logic [15:0] xi, input logic [15:0] yi,
                           input logic [15:0] xo, input logic [15:0] yo,
                           input int early_vs, input int vs_at, input int done_at,
                           input bit hold, input string name);
        exp_t e, got;
        int   accepts;
        bit   seen;
        @(negedge vin_clk);
        n_tests++;
        if (cur_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s ready_before: got %b required 1", name, cur_ready);
        end
        vin_x = xi; vin_y = yi; vout_x = xo; vout_y = yo;
        cfg_valid = 1'b1;
        e.w = model_factor(xi, xo);
        e.h = model_factor(yi, yo);
        exp_q.push_back(e);
        @(posedge vin_clk);
        #1;
        if (!hold) cfg_valid = 1'b0;
        accepts = 1;
        seen    = 1'b0;
        for (int k = 1; k <= done_at + 20 && !seen; k++) begin
            @(negedge vin_clk);
            if (k == early_vs || k == vs_at) frame_vs = 1'b1;
            if (k == early_vs + 3 || k == vs_at + 3) frame_vs = 1'b0;
            if (k >= done_at) cfg_valid = 1'b0;
            if (cfg_valid && cur_ready) accepts++;
            if (k == 1) begin
                n_tests++;
                if (cur_busy !== 1'b1 || cur_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s busy_start: busy=%b err=%b required busy=1 err=0", name, cur_busy, cur_err);
                end
            end
            if (k == done_at - 1) begin
                n_tests++;
                if (cur_busy !== 1'b1) begin
                    n_fail++; $display("FAIL %s busy_before_commit: got %b required 1", name, cur_busy);
                end
            end
            if (cur_done === 1'b1) begin
                seen = 1'b1;
                got  = exp_q.pop_front();
                n_tests++;
                if (k != done_at) begin
                    n_fail++; $display("FAIL %s commit_cycle: got T+%0d required T+%0d", name, k, done_at);
                end
                n_tests++;
                if (cur_w !== got.w || cur_h !== got.h || cur_en !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s factors: got w=%h h=%h en=%b required w=%h h=%h en=1",
                             name, cur_w, cur_h, cur_en, got.w, got.h);
                end
                if (!sel) begin
                    last_w = got.w;
                    last_h = got.h;
                end
            end
        end
        n_tests++;
        if (!seen) begin
            n_fail++; $display("FAIL %s timeout: no cfg_done within T+%0d", name, done_at + 20);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        frame_vs  = 1'b0;
        cfg_valid = 1'b0;
        @(negedge vin_clk);
        n_tests++;
        if (cur_done !== 1'b0 || cur_busy !== 1'b0 || cur_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s after_commit: done=%b busy=%b ready=%b required 0 0 1",
                     name, cur_done, cur_busy, cur_ready);
        end
        if (hold) begin
            n_tests++;
            if (accepts != 1) begin
                n_fail++; $display("FAIL %s accept_count: got %0d required 1", name, accepts);
            end
        end
    endtask

    // Invalid request on the default instance: error after two cycles, active factors kept.
    task automatic run_err(input logic [15:0] xi, input logic [15:0] yi,
                           input logic [15:0] xo, input logic [15:0] yo, input string name);
        @(negedge vin_clk);
        vin_x = xi; vin_y = yi; vout_x = xo; vout_y = yo;
        cfg_valid = 1'b1;
        @(posedge vin_clk);
        #1 cfg_valid = 1'b0;
        @(negedge vin_clk);
        n_tests++;
        if (cur_ready !== 1'b0 || cur_busy !== 1'b0) begin
            n_fail++; $display("FAIL %s err_state: ready=%b busy=%b required 0 0", name, cur_ready, cur_busy);
        end
        @(negedge vin_clk);
        n_tests++;
        if (cur_err !== 1'b1 || cur_w !== last_w || cur_h !== last_h || cur_en !== 1'b1 || cur_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s err_result: err=%b w=%h h=%h en=%b ready=%b required err=1 w=%h h=%h en=1 ready=1",
                     name, cur_err, cur_w, cur_h, cur_en, cur_ready, last_w, last_h);
        end
    endtask

    task automatic test_basic;
        sel = 1'b0;
        run_req(16'd1920, 16'd1080, 16'd1280, 16'd720, 0, 80, 81, 1'b0, "hd_to_720");
        run_req(16'd1920, 16'd1080, 16'd1024, 16'd768, 0, 80, 81, 1'b0, "hd_to_xga");
        run_req(16'd1920, 16'd1080, 16'd640,  16'd480, 0, 70, 71, 1'b0, "hd_to_vga");
    endtask

    task automatic test_immediate;
        sel = 1'b1;
        run_req(16'd1920, 16'd1080, 16'd640, 16'd480, 0, 0, 66, 1'b0, "imm_vga");
        run_req(16'd1920, 16'd1080, 16'd960, 16'd540, 0, 0, 66, 1'b0, "imm_qhd");
        sel = 1'b0;
    endtask

    task automatic test_identity;
        run_req(16'd1920, 16'd1080, 16'd1920, 16'd1080, 0, 70, 71, 1'b0, "identity");
    endtask

    task automatic test_errors;
        run_err(16'd1920, 16'd1080, 16'd0, 16'd720, "zero_xres");
        run_err(16'd1280, 16'd720, 16'd1920, 16'd1080, "upscale");
        run_req(16'd1920, 16'd1080, 16'd1280, 16'd720, 40, 200, 201, 1'b0, "clear_err_late_vs");
    endtask

    task automatic test_back_to_back;
        run_req(16'd1920, 16'd1080, 16'd800, 16'd600, 0, 70, 71, 1'b1, "hold_valid");
    endtask

    task automatic test_random;
        logic [15:0] xi, yi, xo, yo;
        for (int i = 0; i < 3; i++) begin
            xi = 16'($urandom_range(1, 65535));
            yi = 16'($urandom_range(1, 65535));
            xo = 16'($urandom_range(1, int'(xi)));
            yo = 16'($urandom_range(1, int'(yi)));
            run_req(xi, yi, xo, yo, 0, 70, 71, 1'b0, "random");
        end
    endtask

    task automatic test_reset_mid;
        @(negedge vin_clk);
        vin_x = 16'd1920; vin_y = 16'd1080; vout_x = 16'd1280; vout_y = 16'd720;
        cfg_valid = 1'b1;
        @(posedge vin_clk);
        #1 cfg_valid = 1'b0;
        repeat (50) @(negedge vin_clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({w0, h0, en0, busy0, done0, err0} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: w=%h h=%h en=%b busy=%b done=%b err=%b required all zero",
                     w0, h0, en0, busy0, done0, err0);
        end
        @(negedge vin_clk);
        rst_n = 1'b1;
        @(negedge vin_clk);
        n_tests++;
        if (if0.cfg_ready !== 1'b1 || en0 !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: ready=%b en=%b required 1 0", if0.cfg_ready, en0);
        end
        last_w = '0;
        last_h = '0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_immediate();
        test_identity();
        test_errors();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
